// File: rtl/img_pkg.sv
// Shared constants, FSM state type and window pixel indexing for the 3x3 frame-readout stage.
package img_pkg;
    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PIX_W     = 8;
    localparam int WIN_N     = 3;
    localparam int WIN_W     = WIN_N * WIN_N * PIX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // MSB of window pixel (i,j): row-major, pixel (0,0) in the top byte.
    function automatic int win_msb(input int i, input int j);
        return WIN_W - 1 - PIX_W * (WIN_N * i + j);
    endfunction
endpackage

// File: rtl/line_buf.sv
// DEPTH-entry shift delay line: dout is the sample pushed DEPTH enables ago, advanced only on en.
module line_buf
    import img_pkg::*;
#(
    parameter int DEPTH = IMG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/img_win3x3.sv
// Reads a frame from RAM on start and streams all 3x3 windows; first window 61 cycles after start, 1 pixel/cycle,
// reads throttled by a 2-entry skid buffer under win_ready backpressure. IMG_WIN_BIN_EN thresholds pixels on entry.
module img_win3x3
    import img_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] BIN_THRESH = 8'd128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [71:0]       win,
    output logic [4:0]        win_row,
    output logic [4:0]        win_col,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [4:0]        COL_LAST  = 5'(IMG_W - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(IMG_H - 1);
    localparam logic [4:0]        EDGE      = 5'd2;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic inflight_q, inflight_d;
    logic [PIX_W-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0] skid_cnt_q, skid_cnt_d;
    logic [4:0] col_q, col_d, row_q, row_d;
    logic [WIN_N-1:0][WIN_N-1:0][PIX_W-1:0] sh_q, sh_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [4:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic win_valid_q, win_valid_d, win_last_q, win_last_d;

    logic rd_issue, start_acc, src_vld, pop, emit;
    logic [PIX_W-1:0] pix_in, src_pix, lb1_out, lb2_out;

`ifdef IMG_WIN_BIN_EN
    assign pix_in = (ram_rd_data >= BIN_THRESH) ? 8'hFF : 8'h00;
`else
    assign pix_in = ram_rd_data;
    logic unused_thresh;
    assign unused_thresh = ^BIN_THRESH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (rd_issue && addr_q == LAST_ADDR) state_d = ST_DRAIN;
            ST_DRAIN: if (!inflight_q && skid_cnt_q == 2'd0 && win_valid_q && win_ready && win_last_q)
                          state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A read is issued only if the skid can still absorb it alongside the one already in flight.
    always_comb begin
        rd_issue  = 1'b0;
        start_acc = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE:  start_acc = start;
            ST_READ: begin
                busy     = 1'b1;
                rd_issue = ({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < 3'd2;
            end
            ST_DRAIN: busy = 1'b1;
            default:  done = 1'b1;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (start_acc) begin
            addr_d = '0;
        end else if (rd_issue) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
        inflight_d = rd_issue;
    end

    always_comb begin
        src_vld = (skid_cnt_q != 2'd0) || inflight_q;
        src_pix = (skid_cnt_q != 2'd0) ? skid0_q : pix_in;
        pop     = src_vld && (!win_valid_q || win_ready);
        emit    = pop && (row_q >= EDGE) && (col_q >= EDGE);
    end

    // Returning data bypasses the skid when it is empty and the pixel is consumed the same cycle.
    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        if (pop && skid_cnt_q != 2'd0) begin
            skid0_d    = skid1_q;
            skid_cnt_d = skid_cnt_q - 2'd1;
        end
        if (inflight_q && !(pop && skid_cnt_q == 2'd0)) begin
            if (skid_cnt_d == 2'd0) begin
                skid0_d = pix_in;
            end else begin
                skid1_d = pix_in;
            end
            skid_cnt_d = skid_cnt_d + 2'd1;
        end
    end

    line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pop),
        .din  (src_pix),
        .dout (lb1_out)
    );

    line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pop),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sh_d  = sh_q;
        if (start_acc) begin
            col_d = '0;
            row_d = '0;
        end else if (pop) begin
            for (int i = 0; i < WIN_N; i++) begin
                sh_d[i][0] = sh_q[i][1];
                sh_d[i][1] = sh_q[i][2];
            end
            sh_d[0][2] = lb2_out;
            sh_d[1][2] = lb1_out;
            sh_d[2][2] = src_pix;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    always_comb begin
        win_d       = win_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q && !win_ready;
        if (emit) begin
            for (int i = 0; i < WIN_N; i++) begin
                for (int j = 0; j < WIN_N; j++) begin
                    win_d[win_msb(i, j) -: PIX_W] = sh_d[i][j];
                end
            end
            win_row_d   = row_q - EDGE;
            win_col_d   = col_q - EDGE;
            win_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            win_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            skid_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            sh_q        <= '0;
            win_q       <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            skid_cnt_q  <= skid_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sh_q        <= sh_d;
            win_q       <= win_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    assign ram_rd_en   = rd_issue;
    assign ram_rd_addr = addr_q;
    assign win         = win_q;
    assign win_row     = win_row_q;
    assign win_col     = win_col_q;
    assign win_valid   = win_valid_q;
    assign win_last    = win_last_q;
endmodule
